// File: rtl/vector_fetch_ctrl_if.sv
// Client request/response and memory read-request bundle for vector_fetch_ctrl.
// The "slave" modport is the controller side: it serves the client and
// issues memory reads. The "master" modport is the environment side.
interface vector_fetch_ctrl_if #(
    parameter int unsigned EMBEDDING_DIM = 384
);
    logic                       req_valid;
    logic                       req_ready;
    logic [31:0]                req_idx;

    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [EMBEDDING_DIM*32-1:0] rsp_vector;
    logic [31:0]                rsp_doc_idx;
    logic                       rsp_from_cache;

    logic                       mem_req_valid;
    logic                       mem_req_ready;
    logic [31:0]                mem_req_addr;
    logic                       mem_rsp_valid;
    logic [31:0]                mem_rsp_data;

    modport slave (
        input  req_valid, req_idx, rsp_ready, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output req_ready, rsp_valid, rsp_vector, rsp_doc_idx, rsp_from_cache,
               mem_req_valid, mem_req_addr
    );

    modport master (
        output req_valid, req_idx, rsp_ready, mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  req_ready, rsp_valid, rsp_vector, rsp_doc_idx, rsp_from_cache,
               mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/vector_fetch_ctrl.sv
// Vector fetch controller: looks a requested vector up in a combinational
// cache; on a miss reads the REC_WORDS-word record from memory (doc_idx
// first, then elements), fills the cache and returns the vector.
module vector_fetch_ctrl #(
    parameter int unsigned EMBEDDING_DIM = 384
) (
    input  logic                        clk,
    input  logic                        rst_n,
    vector_fetch_ctrl_if.slave          bus,
    output logic [31:0]                 cache_lookup_idx,
    input  logic                        cache_hit,
    input  logic [EMBEDDING_DIM*32-1:0] cache_vector,
    input  logic [31:0]                 cache_doc_idx,
    output logic                        cache_store,
    output logic [31:0]                 cache_store_idx,
    output logic [EMBEDDING_DIM*32-1:0] cache_store_vector,
    output logic [31:0]                 cache_store_doc_idx,
    output logic [31:0]                 hit_count,
    output logic [31:0]                 miss_count
);
    localparam int unsigned REC_WORDS = EMBEDDING_DIM + 1;
    localparam int unsigned CNT_W     = $clog2(REC_WORDS + 1);
    localparam int unsigned VW        = EMBEDDING_DIM * 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_FETCH,
        S_STORE,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [31:0]        r_idx_q;
    logic [CNT_W-1:0]   r_issue_cnt;
    logic [CNT_W-1:0]   r_rcv_cnt;
    logic [VW-1:0]      r_buf_vec;
    logic [31:0]        r_buf_doc;
    logic               r_from_cache;
    logic [31:0]        r_hit_count;
    logic [31:0]        r_miss_count;

    logic               w_issue_more;
    logic               w_issue_fire;
    logic               w_beat;
    logic               w_last_beat;

    assign w_issue_more = (r_issue_cnt < CNT_W'(REC_WORDS));
    assign w_issue_fire = bus.mem_req_valid && bus.mem_req_ready;
    assign w_beat       = (r_state == S_FETCH) && bus.mem_rsp_valid;
    assign w_last_beat  = w_beat && (r_rcv_cnt == CNT_W'(REC_WORDS - 1));

    // Record word address; the multiply wraps modulo 2^32.
    assign bus.mem_req_addr = r_idx_q * 32'(REC_WORDS) + 32'(r_issue_cnt);

    assign cache_lookup_idx    = r_idx_q;
    assign cache_store_idx     = r_idx_q;
    assign cache_store_vector  = r_buf_vec;
    assign cache_store_doc_idx = r_buf_doc;
    assign bus.rsp_vector      = r_buf_vec;
    assign bus.rsp_doc_idx     = r_buf_doc;
    assign bus.rsp_from_cache  = r_from_cache;
    assign hit_count           = r_hit_count;
    assign miss_count          = r_miss_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and handshake/strobe outputs.
    always_comb begin
        w_next_state      = r_state;
        bus.req_ready     = 1'b0;
        bus.rsp_valid     = 1'b0;
        bus.mem_req_valid = 1'b0;
        cache_store       = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_next_state = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                w_next_state = cache_hit ? S_RESP : S_FETCH;
            end
            S_FETCH: begin
                bus.mem_req_valid = w_issue_more;
                if (w_last_beat) begin
                    w_next_state = S_STORE;
                end
            end
            S_STORE: begin
                cache_store  = 1'b1;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Request latch, record assembly, cache capture and saturating statistics.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx_q      <= '0;
            r_issue_cnt  <= '0;
            r_rcv_cnt    <= '0;
            r_buf_vec    <= '0;
            r_buf_doc    <= '0;
            r_from_cache <= 1'b0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_idx_q <= bus.req_idx;
                    end
                end
                S_LOOKUP: begin
                    if (cache_hit) begin
                        r_buf_vec    <= cache_vector;
                        r_buf_doc    <= cache_doc_idx;
                        r_from_cache <= 1'b1;
                        if (r_hit_count != '1) begin
                            r_hit_count <= r_hit_count + 32'd1;
                        end
                    end else begin
                        r_issue_cnt <= '0;
                        r_rcv_cnt   <= '0;
                        if (r_miss_count != '1) begin
                            r_miss_count <= r_miss_count + 32'd1;
                        end
                    end
                end
                S_FETCH: begin
                    if (w_issue_fire) begin
                        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
                    end
                    if (w_beat) begin
                        if (r_rcv_cnt == '0) begin
                            r_buf_doc <= bus.mem_rsp_data;
                        end
                        for (int unsigned e = 0; e < EMBEDDING_DIM; e++) begin
                            if (r_rcv_cnt == CNT_W'(e + 1)) begin
                                r_buf_vec[e*32 +: 32] <= bus.mem_rsp_data;
                            end
                        end
                        r_rcv_cnt <= r_rcv_cnt + CNT_W'(1);
                    end
                end
                S_STORE: begin
                    r_from_cache <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vector_fetch_ctrl.sv
// Self-checking bench for vector_fetch_ctrl (EMBEDDING_DIM=4): cache and
// memory environment models plus a record-level reference predictor.
module tb_vector_fetch_ctrl;
    localparam int unsigned DIM = 4;
    localparam int unsigned VW  = DIM * 32;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [31:0]    cache_lookup_idx;
    logic           cache_hit;
    logic [VW-1:0]  cache_vector;
    logic [31:0]    cache_doc_idx;
    logic           cache_store;
    logic [31:0]    cache_store_idx;
    logic [VW-1:0]  cache_store_vector;
    logic [31:0]    cache_store_doc_idx;
    logic [31:0]    hit_count;
    logic [31:0]    miss_count;

    vector_fetch_ctrl_if #(.EMBEDDING_DIM(DIM)) bus ();

    vector_fetch_ctrl #(.EMBEDDING_DIM(DIM)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .bus                 (bus),
        .cache_lookup_idx    (cache_lookup_idx),
        .cache_hit           (cache_hit),
        .cache_vector        (cache_vector),
        .cache_doc_idx       (cache_doc_idx),
        .cache_store         (cache_store),
        .cache_store_idx     (cache_store_idx),
        .cache_store_vector  (cache_store_vector),
        .cache_store_doc_idx (cache_store_doc_idx),
        .hit_count           (hit_count),
        .miss_count          (miss_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } pend_t;

    bit             bp_mode = 1'b0;
    int             cyc = 0;
    int             last_due = 0;
    int             beats_sent = 0;
    pend_t          pend_q[$];
    logic [VW-1:0]  env_cache_vec [bit [31:0]];
    logic [31:0]    env_cache_doc [bit [31:0]];
    logic [VW-1:0]  ref_vec [bit [31:0]];
    logic [31:0]    ref_doc [bit [31:0]];
    int             exp_hits = 0;
    int             exp_misses = 0;

    logic [31:0]    mon_addrs[$];
    int             mon_mreq_seen = 0;
    int             mon_store_cnt = 0;
    logic [31:0]    mon_store_idx;
    logic [31:0]    mon_store_doc;
    logic [VW-1:0]  mon_store_vec;

    // Backing memory contents: the directed record at 15..19, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'd15:  return 32'd90;
            32'd16:  return 32'd5;
            32'd17:  return 32'd6;
            32'd18:  return 32'd7;
            32'd19:  return 32'd8;
            default: return a * 32'h0001_0003 + 32'h0000_1111;
        endcase
    endfunction

    // Reference: a cached index returns what was cached, otherwise the record
    // at idx*(DIM+1) is read and becomes cached.
    task automatic predict(input logic [31:0] idx, output logic [VW-1:0] v,
                           output logic [31:0] d, output logic fc);
        logic [31:0] base;
        if (ref_vec.exists(idx)) begin
            v = ref_vec[idx];
            d = ref_doc[idx];
            fc = 1'b1;
            exp_hits++;
        end else begin
            base = idx * 32'(DIM + 1);
            d = mem_word(base);
            for (int k = 0; k < int'(DIM); k++) v[k*32 +: 32] = mem_word(base + 32'(k + 1));
            fc = 1'b0;
            ref_vec[idx] = v;
            ref_doc[idx] = d;
            exp_misses++;
        end
    endtask

    // Environment: memory with random ready/latency, combinational cache, monitors.
    initial begin
        bus.mem_req_ready = 1'b1;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        cache_hit         = 1'b0;
        cache_vector      = '0;
        cache_doc_idx     = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (!rst_n) begin
                pend_q.delete();
                last_due = 0;
                bus.mem_rsp_valid = 1'b0;
            end else begin
                bus.mem_req_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
                if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                    bus.mem_rsp_valid = 1'b1;
                    bus.mem_rsp_data  = mem_word(pend_q[0].addr);
                    void'(pend_q.pop_front());
                    beats_sent++;
                end else begin
                    bus.mem_rsp_valid = 1'b0;
                    bus.mem_rsp_data  = $urandom();
                end
            end
            if (env_cache_vec.exists(cache_lookup_idx)) begin
                cache_hit     = 1'b1;
                cache_vector  = env_cache_vec[cache_lookup_idx];
                cache_doc_idx = env_cache_doc[cache_lookup_idx];
            end else begin
                cache_hit     = 1'b0;
                cache_vector  = {$urandom(), $urandom(), $urandom(), $urandom()};
                cache_doc_idx = $urandom();
            end
            @(negedge clk);
            if (rst_n && bus.mem_req_valid) mon_mreq_seen++;
            if (rst_n && bus.mem_req_valid && bus.mem_req_ready) begin
                pend_t p;
                mon_addrs.push_back(bus.mem_req_addr);
                p.addr = bus.mem_req_addr;
                p.due  = cyc + 1 + (bp_mode ? int'($urandom_range(0, 5)) : 0);
                if (p.due <= last_due) p.due = last_due + 1;
                last_due = p.due;
                pend_q.push_back(p);
            end
            if (rst_n && cache_store) begin
                env_cache_vec[cache_store_idx] = cache_store_vector;
                env_cache_doc[cache_store_idx] = cache_store_doc_idx;
                mon_store_cnt++;
                mon_store_idx = cache_store_idx;
                mon_store_doc = cache_store_doc_idx;
                mon_store_vec = cache_store_vector;
            end
        end
    end

    // One client transaction; called and left at 1 time unit after a rising edge.
    task automatic run_req(input logic [31:0] idx, input int stall,
                           output logic [VW-1:0] vec, output logic [31:0] doc,
                           output logic fc, output int lat, output bit tmo,
                           output int hold_bad, output logic rdy_after);
        int k = 0;
        mon_addrs.delete();
        mon_mreq_seen = 0;
        mon_store_cnt = 0;
        tmo = 1'b0; hold_bad = 0; lat = 0; vec = '0; doc = '0; fc = 1'b0; rdy_after = 1'b0;
        bus.req_idx   = idx;
        bus.req_valid = 1'b1;
        bus.rsp_ready = (stall == 0);
        while (!bus.req_ready && k < 50) begin
            @(posedge clk); #1; k++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_idx   = $urandom();
        lat = 1;
        while (!bus.rsp_valid && lat < 400) begin
            @(posedge clk); #1; lat++;
        end
        if (!bus.rsp_valid) begin
            tmo = 1'b1;
            bus.rsp_ready = 1'b0;
            return;
        end
        vec = bus.rsp_vector;
        doc = bus.rsp_doc_idx;
        fc  = bus.rsp_from_cache;
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            if (!bus.rsp_valid || bus.rsp_vector !== vec || bus.rsp_doc_idx !== doc ||
                bus.rsp_from_cache !== fc || bus.req_ready !== 1'b0) hold_bad++;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        rdy_after = bus.req_ready;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_idx   = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_tests++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b exp 0", bus.rsp_valid); end
        n_tests++; if (bus.mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req_valid: got %b exp 0", bus.mem_req_valid); end
        n_tests++; if (cache_store !== 1'b0) begin n_fail++; $display("FAIL reset_cache_store: got %b exp 0", cache_store); end
        n_tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin n_fail++; $display("FAIL reset_counts: got %0d/%0d exp 0/0", hit_count, miss_count); end
        n_tests++; if (cache_lookup_idx !== 32'd0) begin n_fail++; $display("FAIL reset_lookup_idx: got %h exp 0", cache_lookup_idx); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        exp_hits = 0; exp_misses = 0;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b exp 1", bus.req_ready); end
    endtask

    task automatic test_hit();
        logic [VW-1:0] v, ev; logic [31:0] d, ed; logic fc, efc; int lat, hb; bit tmo; logic ra;
        env_cache_vec[32'd7] = {32'd4, 32'd3, 32'd2, 32'd1};
        env_cache_doc[32'd7] = 32'd70;
        ref_vec[32'd7] = {32'd4, 32'd3, 32'd2, 32'd1};
        ref_doc[32'd7] = 32'd70;
        predict(32'd7, ev, ed, efc);
        run_req(32'd7, 0, v, d, fc, lat, tmo, hb, ra);
        n_tests++; if (tmo) begin n_fail++; $display("FAIL hit_timeout: got no rsp_valid exp rsp_valid"); end
        n_tests++; if (v !== ev) begin n_fail++; $display("FAIL hit_vector: got %h exp %h", v, ev); end
        n_tests++; if (d !== ed) begin n_fail++; $display("FAIL hit_doc: got %0d exp %0d", d, ed); end
        n_tests++; if (fc !== 1'b1) begin n_fail++; $display("FAIL hit_from_cache: got %b exp 1", fc); end
        n_tests++; if (lat !== 2) begin n_fail++; $display("FAIL hit_latency: got %0d exp 2", lat); end
        n_tests++; if (hit_count !== 32'(exp_hits)) begin n_fail++; $display("FAIL hit_count: got %0d exp %0d", hit_count, exp_hits); end
        n_tests++; if (mon_mreq_seen !== 0) begin n_fail++; $display("FAIL hit_no_mem_req: got %0d exp 0", mon_mreq_seen); end
        n_tests++; if (mon_store_cnt !== 0) begin n_fail++; $display("FAIL hit_no_store: got %0d exp 0", mon_store_cnt); end
    endtask

    task automatic test_miss();
        logic [VW-1:0] v, ev; logic [31:0] d, ed; logic fc, efc; int lat, hb; bit tmo; logic ra;
        predict(32'd3, ev, ed, efc);
        run_req(32'd3, 0, v, d, fc, lat, tmo, hb, ra);
        n_tests++; if (tmo) begin n_fail++; $display("FAIL miss_timeout: got no rsp_valid exp rsp_valid"); end
        n_tests++; if (v !== {32'd8, 32'd7, 32'd6, 32'd5}) begin n_fail++; $display("FAIL miss_vector: got %h exp %h", v, {32'd8, 32'd7, 32'd6, 32'd5}); end
        n_tests++; if (d !== 32'd90) begin n_fail++; $display("FAIL miss_doc: got %0d exp 90", d); end
        n_tests++; if (fc !== 1'b0) begin n_fail++; $display("FAIL miss_from_cache: got %b exp 0", fc); end
        n_tests++; if (mon_addrs.size() !== 5) begin n_fail++; $display("FAIL miss_req_count: got %0d exp 5", mon_addrs.size()); end
        for (int i = 0; i < 5 && i < mon_addrs.size(); i++) begin
            n_tests++; if (mon_addrs[i] !== 32'(15 + i)) begin n_fail++; $display("FAIL miss_addr%0d: got %0d exp %0d", i, mon_addrs[i], 15 + i); end
        end
        n_tests++; if (mon_store_cnt !== 1) begin n_fail++; $display("FAIL miss_store_pulses: got %0d exp 1", mon_store_cnt); end
        n_tests++; if (mon_store_idx !== 32'd3 || mon_store_doc !== ed || mon_store_vec !== ev) begin
            n_fail++; $display("FAIL miss_store_data: got idx %0d doc %0d vec %h exp idx 3 doc %0d vec %h", mon_store_idx, mon_store_doc, mon_store_vec, ed, ev); end
        n_tests++; if (miss_count !== 32'(exp_misses)) begin n_fail++; $display("FAIL miss_count: got %0d exp %0d", miss_count, exp_misses); end
    endtask

    task automatic test_backpressure();
        logic [VW-1:0] v, ev; logic [31:0] d, ed, idx, base; logic fc, efc; int lat, hb; bit tmo; logic ra;
        idx = 32'd1000 + $urandom_range(0, 999);
        base = idx * 32'd5;
        bp_mode = 1'b1;
        predict(idx, ev, ed, efc);
        run_req(idx, 0, v, d, fc, lat, tmo, hb, ra);
        bp_mode = 1'b0;
        n_tests++; if (tmo) begin n_fail++; $display("FAIL bp_timeout: got no rsp_valid exp rsp_valid"); end
        n_tests++; if (v !== ev || d !== ed || fc !== efc) begin n_fail++; $display("FAIL bp_data: got %h/%0d/%b exp %h/%0d/%b", v, d, fc, ev, ed, efc); end
        n_tests++; if (mon_addrs.size() !== 5) begin n_fail++; $display("FAIL bp_req_count: got %0d exp 5", mon_addrs.size()); end
        for (int i = 0; i < 5 && i < mon_addrs.size(); i++) begin
            n_tests++; if (mon_addrs[i] !== base + 32'(i)) begin n_fail++; $display("FAIL bp_addr%0d: got %h exp %h", i, mon_addrs[i], base + 32'(i)); end
        end
        n_tests++; if (mon_store_cnt !== 1) begin n_fail++; $display("FAIL bp_store_pulses: got %0d exp 1", mon_store_cnt); end
    endtask

    task automatic test_rsp_stall();
        logic [VW-1:0] v, ev; logic [31:0] d, ed; logic fc, efc; int lat, hb; bit tmo; logic ra;
        predict(32'd7, ev, ed, efc);
        run_req(32'd7, 10, v, d, fc, lat, tmo, hb, ra);
        n_tests++; if (tmo) begin n_fail++; $display("FAIL stall_timeout: got no rsp_valid exp rsp_valid"); end
        n_tests++; if (v !== ev || d !== ed || fc !== efc) begin n_fail++; $display("FAIL stall_data: got %h/%0d/%b exp %h/%0d/%b", v, d, fc, ev, ed, efc); end
        n_tests++; if (hb !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d unstable cycles exp 0", hb); end
        n_tests++; if (ra !== 1'b1) begin n_fail++; $display("FAIL stall_req_ready_after: got %b exp 1", ra); end
    endtask

    task automatic test_wrap();
        logic [VW-1:0] v, ev; logic [31:0] d, ed; logic fc, efc; int lat, hb; bit tmo; logic ra;
        predict(32'hFFFF_FFFF, ev, ed, efc);
        run_req(32'hFFFF_FFFF, 0, v, d, fc, lat, tmo, hb, ra);
        n_tests++; if (tmo) begin n_fail++; $display("FAIL wrap_timeout: got no rsp_valid exp rsp_valid"); end
        n_tests++; if (mon_addrs.size() < 1 || mon_addrs[0] !== 32'hFFFF_FFFB) begin
            n_fail++; $display("FAIL wrap_first_addr: got %h (n=%0d) exp fffffffb", mon_addrs.size() > 0 ? mon_addrs[0] : 32'h0, mon_addrs.size()); end
        n_tests++; if (v !== ev || d !== ed || fc !== efc) begin n_fail++; $display("FAIL wrap_data: got %h/%0d/%b exp %h/%0d/%b", v, d, fc, ev, ed, efc); end
    endtask

    task automatic test_reset_mid_fetch();
        logic [VW-1:0] v, ev; logic [31:0] d, ed; logic fc, efc; int lat, hb; bit tmo; logic ra;
        int b0, k;
        mon_store_cnt = 0;
        bp_mode = 1'b1;
        bus.req_idx = 32'd3000;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        b0 = beats_sent;
        k = 0;
        while (beats_sent - b0 < 2 && k < 100) begin
            @(posedge clk); #2; k++;
        end
        n_tests++; if (beats_sent - b0 < 2) begin n_fail++; $display("FAIL rstmid_two_beats: got %0d beats exp 2", beats_sent - b0); end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (bus.rsp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0 || cache_store !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_strobes: got rsp %b mreq %b store %b exp 0 0 0", bus.rsp_valid, bus.mem_req_valid, cache_store); end
        n_tests++; if (hit_count !== 32'd0 || miss_count !== 32'd0 || cache_lookup_idx !== 32'd0) begin
            n_fail++; $display("FAIL rstmid_regs: got hit %0d miss %0d idx %h exp 0 0 0", hit_count, miss_count, cache_lookup_idx); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bp_mode = 1'b0;
        exp_hits = 0; exp_misses = 0;
        @(posedge clk); #1;
        n_tests++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_req_ready: got %b exp 1", bus.req_ready); end
        n_tests++; if (mon_store_cnt !== 0) begin n_fail++; $display("FAIL rstmid_no_store: got %0d exp 0", mon_store_cnt); end
        predict(32'd3000, ev, ed, efc);
        run_req(32'd3000, 0, v, d, fc, lat, tmo, hb, ra);
        n_tests++; if (tmo) begin n_fail++; $display("FAIL rstmid_retry_timeout: got no rsp_valid exp rsp_valid"); end
        n_tests++; if (v !== ev || d !== ed || fc !== 1'b0) begin n_fail++; $display("FAIL rstmid_retry_data: got %h/%0d/%b exp %h/%0d/0", v, d, fc, ev, ed); end
        n_tests++; if (miss_count !== 32'd1 || hit_count !== 32'd0) begin n_fail++; $display("FAIL rstmid_retry_counts: got %0d/%0d exp 0/1", hit_count, miss_count); end
        n_tests++; if (mon_store_cnt !== 1 || mon_addrs.size() !== 5) begin n_fail++; $display("FAIL rstmid_retry_traffic: got %0d stores %0d reqs exp 1 5", mon_store_cnt, mon_addrs.size()); end
    endtask

    task automatic test_random();
        logic [VW-1:0] v, ev; logic [31:0] d, ed, idx; logic fc, efc; int lat, hb, st; bit tmo; logic ra;
        for (int it = 0; it < 24; it++) begin
            idx = 32'd200 + $urandom_range(0, 7);
            st = $urandom_range(0, 3);
            bp_mode = 1'($urandom_range(0, 1));
            predict(idx, ev, ed, efc);
            run_req(idx, st, v, d, fc, lat, tmo, hb, ra);
            n_tests++; if (tmo) begin n_fail++; $display("FAIL rand%0d_timeout: got no rsp_valid exp rsp_valid", it); end
            n_tests++; if (v !== ev || d !== ed || fc !== efc) begin n_fail++; $display("FAIL rand%0d_data: got %h/%0d/%b exp %h/%0d/%b", it, v, d, fc, ev, ed, efc); end
            n_tests++; if (hb !== 0 || ra !== 1'b1) begin n_fail++; $display("FAIL rand%0d_handshake: got hold_bad %0d ready %b exp 0 1", it, hb, ra); end
            if (efc) begin
                n_tests++; if (lat !== 2 || mon_mreq_seen !== 0) begin n_fail++; $display("FAIL rand%0d_hit_path: got lat %0d mreq %0d exp 2 0", it, lat, mon_mreq_seen); end
            end else begin
                n_tests++; if (mon_addrs.size() !== 5 || mon_store_cnt !== 1) begin n_fail++; $display("FAIL rand%0d_miss_path: got %0d reqs %0d stores exp 5 1", it, mon_addrs.size(), mon_store_cnt); end
            end
        end
        bp_mode = 1'b0;
        n_tests++; if (hit_count !== 32'(exp_hits)) begin n_fail++; $display("FAIL rand_hit_count: got %0d exp %0d", hit_count, exp_hits); end
        n_tests++; if (miss_count !== 32'(exp_misses)) begin n_fail++; $display("FAIL rand_miss_count: got %0d exp %0d", miss_count, exp_misses); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_idx   = '0;
        bus.rsp_ready = 1'b0;
        test_reset();
        test_hit();
        test_miss();
        test_backpressure();
        test_rsp_stall();
        test_wrap();
        test_reset_mid_fetch();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion exp completion");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/vector_fetch_ctrl.md
VECTOR_FETCH_CTRL -- requirements
Module: vector_fetch_ctrl

Interface
REQ-001 SHALL have parameter EMBEDDING_DIM, default 384, giving the number of 32-bit elements per vector.
REQ-002 SHALL have parameter REC_WORDS, fixed at EMBEDDING_DIM+1, giving the memory record length in words (word 0 = doc_idx, words 1..EMBEDDING_DIM = elements 0..EMBEDDING_DIM-1).
REQ-003 clk  in  1  clock; all logic on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 req_valid / req_ready  in / out  1 / 1  client fetch request handshake.
REQ-006 req_idx  in  32  vector index requested.
REQ-007 rsp_valid / rsp_ready  out / in  1 / 1  client response handshake.
REQ-008 rsp_vector  out  EMBEDDING_DIM x 32  returned vector (packed, element 0 at index 0).
REQ-009 rsp_doc_idx  out  32  returned document index.
REQ-010 rsp_from_cache  out  1  1 = served by cache hit, 0 = fetched from memory.
REQ-011 cache_lookup_idx  out  32  index driven to the cache lookup port; cache answers combinationally.
REQ-012 cache_hit, cache_vector, cache_doc_idx  in  1, EMBEDDING_DIM x 32, 32  cache lookup result.
REQ-013 cache_store, cache_store_idx, cache_store_vector, cache_store_doc_idx  out  1, 32, EMBEDDING_DIM x 32, 32  cache fill port; write on clk edge with cache_store=1.
REQ-014 mem_req_valid / mem_req_ready  out / in  1 / 1  memory read-request handshake; mem_req_addr  out  32  word address.
REQ-015 mem_rsp_valid  in  1, mem_rsp_data  in  32  read data; in-order, one word per request, no backpressure.
REQ-016 hit_count, miss_count  out  32 each  lookup statistics.

Function
REQ-017 SHALL implement FSM states IDLE, LOOKUP, FETCH, STORE, RESP; one request processed at a time.
REQ-018 IDLE: req_ready=1 (only state where req_ready=1); on req_valid, latch req_idx into idx_q and move to LOOKUP.
REQ-019 cache_lookup_idx SHALL equal idx_q at all times (registered, no combinational path from req_idx).
REQ-020 LOOKUP (exactly 1 cycle): if cache_hit=1, latch cache_vector/cache_doc_idx, set from_cache=1, increment hit_count, go to RESP; else clear issue/receive counters, increment miss_count, go to FETCH.
REQ-021 FETCH: mem_req_valid=1 while issue_cnt < REC_WORDS; mem_req_addr = idx_q*REC_WORDS + issue_cnt, modulo 2^32; issue_cnt increments on mem_req_valid && mem_req_ready.
REQ-022 FETCH: each mem_rsp_valid beat is written to word rcv_cnt of the record buffer (0 -> doc_idx, k -> element k-1); rcv_cnt then increments; multiple outstanding requests are allowed.
REQ-023 Move FETCH -> STORE in the cycle after the beat with rcv_cnt = REC_WORDS-1 is accepted.
REQ-024 STORE (exactly 1 cycle): cache_store=1 with cache_store_idx=idx_q and the assembled vector/doc_idx; from_cache=0; go to RESP.
REQ-025 cache_store SHALL be 0 in every state other than STORE.
REQ-026 RESP: rsp_valid=1 with rsp_vector, rsp_doc_idx, rsp_from_cache stable; on rsp_ready=1, go to IDLE; rsp_ready may already be high in the first RESP cycle.
REQ-027 mem_rsp_valid outside FETCH SHALL be ignored; req_valid outside IDLE SHALL not be accepted.
REQ-028 hit_count and miss_count SHALL saturate at 0xFFFFFFFF.
REQ-029 Latency: hit = 2 cycles from accept to rsp_valid; miss = 1 (LOOKUP) + FETCH duration + 1 (STORE) cycles.

Reset
REQ-030 On rst_n=0 at any time, including mid-FETCH: state=IDLE; all counters, idx_q, and buffers = 0; rsp_valid=0; mem_req_valid=0; cache_store=0; req_ready=1 after reset is released; the memory subsystem is reset together with this block, so no stale beats can arrive.

Verification (EMBEDDING_DIM=4, REC_WORDS=5)
REQ-031 Hit: cache model holds idx 7 -> vector {1,2,3,4}, doc 70; request 7 -> rsp_valid 2 cycles after accept, rsp_vector {1,2,3,4}, doc 70, from_cache=1, hit_count=1, no mem_req_valid.
REQ-032 Miss: empty cache, memory words 15..19 = {90,5,6,7,8}; request 3 -> addresses 15..19 issued, cache_store one pulse with idx 3, doc 90, vector {5,6,7,8}; response from_cache=0, miss_count=1.
REQ-033 Backpressure: mem_req_ready toggles randomly and mem_rsp_valid is delayed 0-5 cycles -> identical data, exactly 5 requests issued, no duplicate addresses.
REQ-034 Response stall: rsp_ready=0 for 10 cycles -> rsp_valid and data held stable, req_ready=0 throughout; after rsp_ready=1, req_ready=1 next cycle.
REQ-035 Wrap: request idx 0xFFFFFFFF -> first address = 0xFFFFFFFB (modulo 2^32).
REQ-036 Reset mid-FETCH after 2 beats -> all outputs return to reset values, no cache_store pulse; a new request to the same idx is then processed fully and correctly.
